// File: rtl/shift_queue.sv
// rtl/shift_queue.sv - collapsing age-ordered queue, slot 0 oldest, any-slot dequeue with shift-down.
// Optional occupancy output port guarded by SHIFT_QUEUE_COUNT_EN.
module shift_queue #(
  parameter int N_ENTRIES   = 8,
  parameter int ENTRY_WIDTH = 32,
  localparam int PTR_WIDTH  = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
  localparam int CTR_WIDTH  = PTR_WIDTH + 1
) (
  input  logic                                    clk,
  input  logic                                    rst_aL,
  output logic                                    enq_ready,
  input  logic                                    enq_valid,
  input  logic [ENTRY_WIDTH-1:0]                  enq_data,
  input  logic                                    deq_ready,
  input  logic [N_ENTRIES-1:0]                    deq_sel_onehot,
  output logic                                    deq_valid,
  output logic [ENTRY_WIDTH-1:0]                  deq_data,
  input  logic [N_ENTRIES-1:0]                    wr_en,
  input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]   wr_data,
  output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]   entry_douts
`ifdef SHIFT_QUEUE_COUNT_EN
  ,
  output logic [CTR_WIDTH-1:0]                    count
`endif
);

  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_q, entry_d;
  logic [N_ENTRIES-1:0]                  valid_q, valid_d;
  logic [CTR_WIDTH-1:0]                  count_q, count_d;

  logic [N_ENTRIES:0][ENTRY_WIDTH-1:0]   ow_ext;
  logic [N_ENTRIES:0]                    valid_ext;
  logic [PTR_WIDTH-1:0]                  sel_idx;
  logic [CTR_WIDTH-1:0]                  tail;
  logic                                  enq_fire;
  logic                                  deq_fire;

  // An all-zero select means "oldest", which is slot 0.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (deq_sel_onehot[i]) sel_idx = PTR_WIDTH'(i);
    end
  end

  assign enq_ready = (count_q != CTR_WIDTH'(N_ENTRIES));
  assign deq_valid = valid_q[sel_idx];
  assign deq_data  = entry_q[sel_idx];
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_ready && deq_valid;

  always_comb begin
    ow_ext    = '0;
    valid_ext = {1'b0, valid_q};
    for (int i = 0; i < N_ENTRIES; i++) begin
      ow_ext[i] = (wr_en[i] && valid_q[i]) ? wr_data[i] : entry_q[i];
    end

    entry_d = ow_ext[N_ENTRIES-1:0];
    valid_d = valid_q;

    // Slots at and above the dequeued one take their upper neighbour; the
    // extra zero slot at the top clears the vacated tail.
    if (deq_fire) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (PTR_WIDTH'(i) >= sel_idx) begin
          entry_d[i] = ow_ext[i+1];
          valid_d[i] = valid_ext[i+1];
        end
      end
    end

    tail = deq_fire ? (count_q - CTR_WIDTH'(1)) : count_q;
    if (enq_fire) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (CTR_WIDTH'(i) == tail) begin
          entry_d[i] = enq_data;
          valid_d[i] = 1'b1;
        end
      end
    end

    count_d = count_q;
    if (enq_fire && !deq_fire) count_d = count_q + CTR_WIDTH'(1);
    if (deq_fire && !enq_fire) count_d = count_q - CTR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      entry_q <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    entry_douts = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid_q[i]) entry_douts[i] = entry_q[i];
    end
  end

`ifdef SHIFT_QUEUE_COUNT_EN
  assign count = count_q;
`endif

endmodule

// File: tb/tb_shift_queue.sv
// tb/tb_shift_queue.sv - directed self-checking bench for shift_queue.
module tb_shift_queue;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst_aL;
  logic                 enq_ready;
  logic                 enq_valid;
  logic [W-1:0]         enq_data;
  logic                 deq_ready;
  logic [N-1:0]         deq_sel_onehot;
  logic                 deq_valid;
  logic [W-1:0]         deq_data;
  logic [N-1:0]         wr_en;
  logic [N-1:0][W-1:0]  wr_data;
  logic [N-1:0][W-1:0]  entry_douts;
`ifdef SHIFT_QUEUE_COUNT_EN
  logic [CW-1:0]        count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  shift_queue #(.N_ENTRIES(N), .ENTRY_WIDTH(W)) dut (
    .clk(clk),
    .rst_aL(rst_aL),
    .enq_ready(enq_ready),
    .enq_valid(enq_valid),
    .enq_data(enq_data),
    .deq_ready(deq_ready),
    .deq_sel_onehot(deq_sel_onehot),
    .deq_valid(deq_valid),
    .deq_data(deq_data),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .entry_douts(entry_douts)
`ifdef SHIFT_QUEUE_COUNT_EN
    ,
    .count(count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0;
    enq_data = '0;
    deq_ready = 1'b0;
    deq_sel_onehot = '0;
    wr_en = '0;
    wr_data = '0;
  endtask

  task automatic enq(input logic [W-1:0] d);
    enq_valid = 1'b1;
    enq_data = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_aL = 1'b0;
    repeat (3) tick();
    rst_aL = 1'b1;
  endtask

  task automatic check_count(input string name, input int exp);
`ifdef SHIFT_QUEUE_COUNT_EN
    tests_run++;
    if (count !== CW'(exp)) begin
      tests_failed++;
      $display("FAIL %s: count=%0d expected %0d", name, count, exp);
    end
`else
    if (name.len() == 0 && exp < 0) $display("unreachable");
`endif
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (enq_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
    tests_run++;
    if (deq_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid); end
    tests_run++;
    if (deq_data !== '0) begin tests_failed++; $display("FAIL reset_deq_data: got %h expected 0", deq_data); end
    tests_run++;
    if (entry_douts !== '0) begin tests_failed++; $display("FAIL reset_douts: got %h expected 0", entry_douts); end
    check_count("reset_count", 0);
  endtask

  task automatic test_enqueue();
    enq(32'h12345678);
    tests_run++;
    if (enq_ready !== 1'b1) begin tests_failed++; $display("FAIL enq1_ready: got %b expected 1", enq_ready); end
    tests_run++;
    if (deq_valid !== 1'b1) begin tests_failed++; $display("FAIL enq1_deq_valid: got %b expected 1", deq_valid); end
    tests_run++;
    if (deq_data !== 32'h12345678) begin tests_failed++; $display("FAIL enq1_deq_data: got %h expected 12345678", deq_data); end
    check_count("enq1_count", 1);

    enq(32'h87654321);
    tests_run++;
    if (deq_data !== 32'h12345678) begin tests_failed++; $display("FAIL enq2_deq_data: got %h expected 12345678", deq_data); end
    check_count("enq2_count", 2);

    enq(32'hABCDEF01);
    check_count("enq3_count", 3);
    tests_run++;
    if (entry_douts[1] !== 32'h87654321) begin tests_failed++; $display("FAIL enq3_slot1: got %h expected 87654321", entry_douts[1]); end
    tests_run++;
    if (entry_douts[2] !== 32'hABCDEF01) begin tests_failed++; $display("FAIL enq3_slot2: got %h expected abcdef01", entry_douts[2]); end
  endtask

  task automatic test_deq_oldest();
    deq_ready = 1'b1;
    deq_sel_onehot = '0;
    tick();
    idle();
    tests_run++;
    if (deq_data !== 32'h87654321) begin tests_failed++; $display("FAIL deq0_deq_data: got %h expected 87654321", deq_data); end
    tests_run++;
    if (entry_douts[1] !== 32'hABCDEF01) begin tests_failed++; $display("FAIL deq0_slot1: got %h expected abcdef01", entry_douts[1]); end
    tests_run++;
    if (entry_douts[2] !== '0) begin tests_failed++; $display("FAIL deq0_slot2: got %h expected 0", entry_douts[2]); end
    check_count("deq0_count", 2);
  endtask

  task automatic test_deq_middle();
    do_reset();
    enq(32'h12345678);
    enq(32'h87654321);
    enq(32'hABCDEF01);
    deq_ready = 1'b1;
    deq_sel_onehot = 8'b0000_0010;
    enq_valid = 1'b1;
    enq_data = 32'h55;
    tick();
    idle();
    tests_run++;
    if (entry_douts[0] !== 32'h12345678) begin tests_failed++; $display("FAIL mid_slot0: got %h expected 12345678", entry_douts[0]); end
    tests_run++;
    if (entry_douts[1] !== 32'hABCDEF01) begin tests_failed++; $display("FAIL mid_slot1: got %h expected abcdef01", entry_douts[1]); end
    tests_run++;
    if (entry_douts[2] !== 32'h55) begin tests_failed++; $display("FAIL mid_slot2: got %h expected 55", entry_douts[2]); end
    tests_run++;
    if (entry_douts[3] !== '0) begin tests_failed++; $display("FAIL mid_slot3: got %h expected 0", entry_douts[3]); end
    check_count("mid_count", 3);

    // Select an invalid slot: deq_valid low and nothing changes.
    deq_ready = 1'b1;
    deq_sel_onehot = 8'b0010_0000;
    #1;
    tests_run++;
    if (deq_valid !== 1'b0) begin tests_failed++; $display("FAIL inv_sel_valid: got %b expected 0", deq_valid); end
    tick();
    idle();
    tests_run++;
    if (entry_douts[2] !== 32'h55) begin tests_failed++; $display("FAIL inv_sel_slot2: got %h expected 55", entry_douts[2]); end
    check_count("inv_sel_count", 3);
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) enq(32'h100 + 32'(i));
    tests_run++;
    if (enq_ready !== 1'b0) begin tests_failed++; $display("FAIL full_enq_ready: got %b expected 0", enq_ready); end
    check_count("full_count", 8);
    tests_run++;
    if (entry_douts[7] !== 32'h104) begin tests_failed++; $display("FAIL full_slot7: got %h expected 104", entry_douts[7]); end

    enq_valid = 1'b1;
    enq_data = 32'hBAD;
    deq_ready = 1'b1;
    deq_sel_onehot = '0;
    tick();
    idle();
    tests_run++;
    if (enq_ready !== 1'b1) begin tests_failed++; $display("FAIL full_deq_ready: got %b expected 1", enq_ready); end
    tests_run++;
    if (entry_douts[0] !== 32'hABCDEF01) begin tests_failed++; $display("FAIL full_deq_slot0: got %h expected abcdef01", entry_douts[0]); end
    tests_run++;
    if (entry_douts[6] !== 32'h104) begin tests_failed++; $display("FAIL full_deq_slot6: got %h expected 104", entry_douts[6]); end
    tests_run++;
    if (entry_douts[7] !== '0) begin tests_failed++; $display("FAIL full_deq_slot7: got %h expected 0", entry_douts[7]); end
    check_count("full_deq_count", 7);
  endtask

  task automatic test_overwrite();
    // Slot 7 is invalid, so its write must be dropped.
    wr_en = 8'b1000_0010;
    wr_data[1] = 32'hDEAD;
    wr_data[7] = 32'hFFFF;
    deq_ready = 1'b1;
    deq_sel_onehot = '0;
    tick();
    idle();
    tests_run++;
    if (entry_douts[0] !== 32'hDEAD) begin tests_failed++; $display("FAIL ow_slot0: got %h expected dead", entry_douts[0]); end
    tests_run++;
    if (entry_douts[5] !== 32'h104) begin tests_failed++; $display("FAIL ow_slot5: got %h expected 104", entry_douts[5]); end
    tests_run++;
    if (entry_douts[7:6] !== '0) begin tests_failed++; $display("FAIL ow_top: got %h expected 0", entry_douts[7:6]); end
    check_count("ow_count", 6);

    wr_en = 8'b0000_0100;
    wr_data[2] = 32'hC0DE;
    tick();
    idle();
    tests_run++;
    if (entry_douts[2] !== 32'hC0DE) begin tests_failed++; $display("FAIL ow_inplace: got %h expected c0de", entry_douts[2]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    deq_ready = 1'b1;
    tick();
    idle();
    tests_run++;
    if (deq_valid !== 1'b0 || entry_douts !== '0) begin tests_failed++; $display("FAIL empty_deq: valid=%b douts=%h expected 0", deq_valid, entry_douts); end
    check_count("empty_deq_count", 0);

    enq(32'hAAAA0001);
    enq_valid = 1'b1;
    enq_data = 32'hBBBB0002;
    deq_ready = 1'b1;
    tick();
    enq_data = 32'hCCCC0003;
    tick();
    idle();
    tests_run++;
    if (entry_douts[0] !== 32'hCCCC0003) begin tests_failed++; $display("FAIL b2b_slot0: got %h expected cccc0003", entry_douts[0]); end
    tests_run++;
    if (entry_douts[1] !== '0) begin tests_failed++; $display("FAIL b2b_slot1: got %h expected 0", entry_douts[1]); end
    check_count("b2b_count", 1);

    enq_valid = 1'b1;
    enq_data = 32'h77;
    wr_en = '1;
    wr_data[0] = 32'h99;
    rst_aL = 1'b0;
    tick();
    idle();
    rst_aL = 1'b1;
    tests_run++;
    if (entry_douts !== '0 || deq_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: douts=%h valid=%b expected 0", entry_douts, deq_valid); end
    check_count("mid_reset_count", 0);
  endtask

  initial begin
    idle();
    rst_aL = 1'b0;
    test_reset();
    test_enqueue();
    test_deq_oldest();
    test_deq_middle();
    test_full();
    test_overwrite();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
